uart_tx_fifo_ctrl: RTL and testbench

//  Transmit-side controller for the 16550A TX path. Buffers CPU writes to THR in a

---
 rtl/uart_tx_fifo_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: 16550A transmit-side controller. Buffers CPU THR writes in a
// DEPTH-entry FIFO (or a 1-entry holding register when FIFOs are disabled), presents
// the head byte to the serializer, consumes one entry per pop rising edge, and
// produces LSR THRE/TEMT plus the THR-empty interrupt request.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fifo_en               FCR[0]; 0 = single holding register
//   tx_fifo_rst           FCR[2] write pulse, flushes the FIFO
//   thr_wr, thr_din       CPU write strobe and data
//   pop                   serializer read request (level, may be held)
//   sreg_empty            serializer shift register empty
//   etbei, thre_int_clr   IER[1] and THRE-source IIR read pulse
//   dout, thres           head byte, nothing-to-send flag
//   thre, temt            LSR[5], LSR[6]
//   thre_int              THR-empty interrupt pending
//   tx_level, wr_ovf      occupancy, sticky write-dropped flag
module uart_tx_fifo_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_en,
    input  logic             tx_fifo_rst,
    input  logic             thr_wr,
    input  logic [WIDTH-1:0] thr_din,
    input  logic             pop,
    input  logic             sreg_empty,
    input  logic             etbei,
    input  logic             thre_int_clr,
    output logic [WIDTH-1:0] dout,
    output logic             thres,
    output logic             thre,
    output logic             temt,
    output logic             thre_int,
    output logic [AW:0]      tx_level,
    output logic             wr_ovf
);

    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } int_state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_pop_q;
    logic             r_pop_edge;
    logic             r_wr_ovf;
    logic             r_fifo_en_q;
    logic             r_thre_q;
    logic             r_etbei_q;
    logic             r_thre_int;
    int_state_t       r_state;

    logic [LW-1:0]    w_cap;
    logic             w_full;
    logic             w_empty;
    logic             w_flush;
    logic             w_wr_acc;
    logic             w_wr_drop;
    logic             w_rd_acc;
    logic             w_thre_rise;
    logic             w_etbei_rise;

    // Occupancy and flush decode; full uses the registered level so a same-clk
    // consume never frees room for that clk's write.
    assign w_cap     = fifo_en ? LW'(DEPTH) : LW'(1);
    assign w_full    = (r_level == w_cap);
    assign w_empty   = (r_level == '0);
    assign w_flush   = tx_fifo_rst | (fifo_en ^ r_fifo_en_q);
    assign w_wr_acc  = thr_wr & ~w_full & ~w_flush;
    assign w_wr_drop = thr_wr & w_full & ~w_flush;
    assign w_rd_acc  = r_pop_edge & ~w_empty & ~w_flush;

    assign dout     = r_mem[r_rd_ptr];
    assign thres    = w_empty;
    assign thre     = w_empty;
    assign temt     = w_empty & sreg_empty;
    assign thre_int = r_thre_int;
    assign tx_level = r_level;
    assign wr_ovf   = r_wr_ovf;

    // FIFO storage, pointers, level and pop-edge pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_pop_q     <= 1'b0;
            r_pop_edge  <= 1'b0;
            r_wr_ovf    <= 1'b0;
            r_fifo_en_q <= 1'b0;
        end else begin
            r_pop_q     <= pop;
            r_fifo_en_q <= fifo_en;
            // A flush also kills any pop edge in flight.
            r_pop_edge  <= pop & ~r_pop_q & ~w_flush;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_wr_ovf <= 1'b0;
            end else begin
                if (w_wr_acc) begin
                    r_mem[r_wr_ptr] <= thr_din;
                    r_wr_ptr        <= r_wr_ptr + AW'(1);
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_wr_acc && !w_rd_acc) begin
                    r_level <= r_level + LW'(1);
                end else if (!w_wr_acc && w_rd_acc) begin
                    r_level <= r_level - LW'(1);
                end
                if (w_wr_drop) begin
                    r_wr_ovf <= 1'b1;
                end
            end
        end
    end

    assign w_thre_rise  = w_empty & ~r_thre_q;
    assign w_etbei_rise = etbei & ~r_etbei_q;

    // THR-empty interrupt FSM; an accepted write blocks a same-clk set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_thre_int <= 1'b0;
            r_thre_q   <= 1'b1;
            r_etbei_q  <= 1'b0;
        end else begin
            r_thre_q  <= w_empty;
            r_etbei_q <= etbei;
            case (r_state)
                ST_IDLE: begin
                    if (etbei && (w_thre_rise || (w_etbei_rise && w_empty)) && !w_wr_acc) begin
                        r_state    <= ST_PEND;
                        r_thre_int <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (thre_int_clr || w_wr_acc || !etbei) begin
                        r_state    <= ST_IDLE;
                        r_thre_int <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_thre_int <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: FIFO order, pop edge handling, overflow,
// 16450 mode, flush, THRE interrupt and asynchronous reset.
module tb_uart_tx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fifo_en;
    logic       tx_fifo_rst;
    logic       thr_wr;
    logic [7:0] thr_din;
    logic       pop;
    logic       sreg_empty;
    logic       etbei;
    logic       thre_int_clr;
    logic [7:0] dout;
    logic       thres;
    logic       thre;
    logic       temt;
    logic       thre_int;
    logic [4:0] tx_level;
    logic       wr_ovf;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_fifo_ctrl #(.DEPTH(16), .AW(4), .WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_en      (fifo_en),
        .tx_fifo_rst  (tx_fifo_rst),
        .thr_wr       (thr_wr),
        .thr_din      (thr_din),
        .pop          (pop),
        .sreg_empty   (sreg_empty),
        .etbei        (etbei),
        .thre_int_clr (thre_int_clr),
        .dout         (dout),
        .thres        (thres),
        .thre         (thre),
        .temt         (temt),
        .thre_int     (thre_int),
        .tx_level     (tx_level),
        .wr_ovf       (wr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"},    32'(tx_level), 32'd0);
        chk({tag, "_dout"},     32'(dout),     32'h00);
        chk({tag, "_thres"},    32'(thres),    32'd1);
        chk({tag, "_thre"},     32'(thre),     32'd1);
        chk({tag, "_temt"},     32'(temt),     32'd1);
        chk({tag, "_thre_int"}, 32'(thre_int), 32'd0);
        chk({tag, "_wr_ovf"},   32'(wr_ovf),   32'd0);
    endtask

    initial begin
        rst_n = 1'b1; fifo_en = 1'b0; tx_fifo_rst = 1'b0; thr_wr = 1'b0; thr_din = 8'h00;
        pop = 1'b0; sreg_empty = 1'b1; etbei = 1'b0; thre_int_clr = 1'b0;
        #1 rst_n = 1'b0;
        #10;
        chk_reset_vals("por");
        tick();
        rst_n = 1'b1;

        // Three writes, then a long pop consumes exactly one entry.
        fifo_en = 1'b1;
        tick();
        thr_wr = 1'b1;
        thr_din = 8'h41; tick();
        chk("wr1_thres", 32'(thres), 32'd0);
        thr_din = 8'h42; tick();
        thr_din = 8'h43; tick();
        thr_wr = 1'b0;
        chk("wr3_level", 32'(tx_level), 32'd3);
        chk("wr3_dout",  32'(dout),     32'h41);
        pop = 1'b1;
        tick();
        chk("pop1_level", 32'(tx_level), 32'd3);
        chk("pop1_dout",  32'(dout),     32'h41);
        tick();
        chk("pop2_level", 32'(tx_level), 32'd2);
        chk("pop2_dout",  32'(dout),     32'h42);
        for (int i = 0; i < 14; i++) tick();
        chk("pop16_level", 32'(tx_level), 32'd2);
        chk("pop16_dout",  32'(dout),     32'h42);
        pop = 1'b0;
        tick();

        // Grow to 5 entries, flush, temt follows sreg_empty.
        thr_wr = 1'b1;
        thr_din = 8'h44; tick();
        thr_din = 8'h45; tick();
        thr_din = 8'h46; tick();
        thr_wr = 1'b0;
        chk("five_level", 32'(tx_level), 32'd5);
        chk("five_temt",  32'(temt),     32'd0);
        tx_fifo_rst = 1'b1; tick(); tx_fifo_rst = 1'b0;
        chk("flush_level", 32'(tx_level), 32'd0);
        chk("flush_thres", 32'(thres),    32'd1);
        chk("flush_thre",  32'(thre),     32'd1);
        chk("flush_temt",  32'(temt),     32'd1);
        sreg_empty = 1'b0; #1;
        chk("temt_busy", 32'(temt), 32'd0);
        sreg_empty = 1'b1; #1;
        chk("temt_idle", 32'(temt), 32'd1);

        // Seventeen writes: last one dropped, then drain in order.
        thr_wr = 1'b1;
        for (int i = 0; i < 17; i++) begin
            thr_din = 8'(i);
            tick();
            if (i == 15) begin
                chk("ovf_full_level", 32'(tx_level), 32'd16);
                chk("ovf_full_flag",  32'(wr_ovf),   32'd0);
            end
        end
        thr_wr = 1'b0;
        chk("ovf_level", 32'(tx_level), 32'd16);
        chk("ovf_flag",  32'(wr_ovf),   32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(dout), 32'(i));
            pop = 1'b1; tick(); tick();
            pop = 1'b0; tick();
        end
        chk("drain_level", 32'(tx_level), 32'd0);
        chk("drain_thre",  32'(thre),     32'd1);
        thr_wr = 1'b1; thr_din = 8'h77; tick(); thr_wr = 1'b0;
        chk("wrap_dout", 32'(dout), 32'h77);
        tx_fifo_rst = 1'b1; tick(); tx_fifo_rst = 1'b0;
        chk("flush_ovf", 32'(wr_ovf), 32'd0);

        // Full FIFO: write in the consume clk is still dropped.
        thr_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            thr_din = 8'(8'h80 + i);
            tick();
        end
        thr_wr = 1'b0;
        pop = 1'b1; tick();
        thr_wr = 1'b1; thr_din = 8'hEE; tick();
        thr_wr = 1'b0; pop = 1'b0;
        chk("coinc_level", 32'(tx_level), 32'd15);
        chk("coinc_ovf",   32'(wr_ovf),   32'd1);
        chk("coinc_dout",  32'(dout),     32'h81);
        tx_fifo_rst = 1'b1; tick(); tx_fifo_rst = 1'b0;

        // 16450 mode: single holding register.
        fifo_en = 1'b0;
        tick();
        thr_wr = 1'b1;
        thr_din = 8'h55; tick();
        thr_din = 8'h66; tick();
        thr_wr = 1'b0;
        chk("nf_level", 32'(tx_level), 32'd1);
        chk("nf_ovf",   32'(wr_ovf),   32'd1);
        chk("nf_dout",  32'(dout),     32'h55);
        pop = 1'b1; tick(); tick(); pop = 1'b0; tick();
        chk("nf_drain", 32'(tx_level), 32'd0);

        // THRE interrupt.
        etbei = 1'b1; tick();
        chk("int_etbei_rise", 32'(thre_int), 32'd1);
        thre_int_clr = 1'b1; tick(); thre_int_clr = 1'b0;
        chk("int_clr", 32'(thre_int), 32'd0);
        thr_wr = 1'b1; thr_din = 8'h12; tick(); thr_wr = 1'b0;
        chk("int_wr_thre", 32'(thre), 32'd0);
        pop = 1'b1; tick(); tick();
        chk("int_thre_rise", 32'(thre),     32'd1);
        chk("int_same_clk",  32'(thre_int), 32'd0);
        tick();
        pop = 1'b0;
        chk("int_pend", 32'(thre_int), 32'd1);
        thre_int_clr = 1'b1; tick(); thre_int_clr = 1'b0;
        chk("int_clr2", 32'(thre_int), 32'd0);
        etbei = 1'b0; tick();
        etbei = 1'b1; tick();
        chk("int_pend2", 32'(thre_int), 32'd1);
        thr_wr = 1'b1; thr_din = 8'h34; tick(); thr_wr = 1'b0;
        chk("int_wr_clr", 32'(thre_int), 32'd0);
        chk("int_wr_lvl", 32'(tx_level), 32'd1);

        // Asynchronous reset mid-drain.
        chk("pre_rst_ovf",  32'(wr_ovf), 32'd1);
        chk("pre_rst_dout", 32'(dout),   32'h34);
        pop = 1'b1; tick();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        pop = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
